// File: rtl/ym_reg_writer.sv
// ============================================================================
//  Module   : ym_reg_writer
//  Purpose  : Queued CPU-side register writer for YM2203 (addr/data phases + busy poll)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ym_reg_writer #(
    parameter int DEPTH    = 16,
    parameter int POLL_EN  = 1,
    parameter int SETTLE   = 1,
    parameter int POLL_MAX = 255
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       CE_CPU,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic                       IN_CHIP,
    input  logic [7:0]                 IN_REG,
    input  logic [7:0]                 IN_DATA,
    output logic                       YM_SEL,
    output logic                       YM_A0,
    output logic                       YM_WE,
    output logic [7:0]                 YM_DO,
    input  logic [7:0]                 YM_DI,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic                       BUSY,
    output logic                       TIMEOUT
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam int                c_LW       = c_AW + 1;
    localparam logic [c_LW-1:0]   c_FULL     = c_LW'(DEPTH);
    localparam logic [7:0]        c_SETTLE   = 8'(SETTLE);
    localparam logic [7:0]        c_POLL_MAX = 8'(POLL_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_POLL} state_t;

    // Request FIFO: {chip, reg, data}
    logic [16:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wp, r_rp;
    logic [c_LW-1:0] r_level;
    logic            w_push, w_pop, w_ready;
    logic [16:0]     w_head;

    state_t          r_state, w_state_nx;
    logic            r_sel, r_a0, r_we, r_to;
    logic [7:0]      r_do, r_reg, r_dat, r_cnt, r_set;
    logic            w_sel_nx, w_a0_nx, w_we_nx, w_to_nx;
    logic [7:0]      w_do_nx, w_reg_nx, w_dat_nx, w_cnt_nx, w_set_nx;
    logic            w_fm;
    logic            w_unused_di;

    assign w_ready     = (r_level != c_FULL);
    assign w_push      = IN_VALID & w_ready;
    assign w_head      = r_mem[r_rp];
    assign w_unused_di = ^YM_DI[6:0];

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wp] <= {IN_CHIP, IN_REG, IN_DATA};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Timer/prescaler registers 2D..2F never raise the busy flag.
    assign w_fm = (POLL_EN != 0) && (r_reg >= 8'h10) &&
                  !((r_reg >= 8'h2D) && (r_reg <= 8'h2F));

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_a0_nx    = r_a0;
        w_we_nx    = r_we;
        w_do_nx    = r_do;
        w_reg_nx   = r_reg;
        w_dat_nx   = r_dat;
        w_cnt_nx   = r_cnt;
        w_set_nx   = r_set;
        w_to_nx    = r_to;
        w_pop      = 1'b0;
        if (CE_CPU) begin
            case (r_state)
                S_IDLE: begin
                    if (r_level != '0) begin
                        w_pop      = 1'b1;
                        w_sel_nx   = w_head[16];
                        w_reg_nx   = w_head[15:8];
                        w_dat_nx   = w_head[7:0];
                        w_a0_nx    = 1'b0;
                        w_we_nx    = 1'b1;
                        w_do_nx    = w_head[15:8];
                        w_state_nx = S_ADDR;
                    end
                end
                S_ADDR: begin
                    w_a0_nx    = 1'b1;
                    w_we_nx    = 1'b1;
                    w_do_nx    = r_dat;
                    w_state_nx = S_DATA;
                end
                S_DATA: begin
                    w_we_nx = 1'b0;
                    if (w_fm) begin
                        w_a0_nx    = 1'b0;
                        w_cnt_nx   = '0;
                        w_set_nx   = '0;
                        w_state_nx = S_POLL;
                    end else begin
                        w_a0_nx    = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end
                S_POLL: begin
                    if (r_set < c_SETTLE) begin
                        w_set_nx = r_set + 8'd1;
                    end else if (!YM_DI[7]) begin
                        w_a0_nx    = 1'b1;
                        w_state_nx = S_IDLE;
                    end else if ((r_cnt + 8'd1) == c_POLL_MAX) begin
                        w_to_nx    = 1'b1;
                        w_a0_nx    = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_cnt_nx = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_a0_nx    = 1'b1;
                    w_we_nx    = 1'b0;
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
            r_a0    <= 1'b1;
            r_we    <= 1'b0;
            r_do    <= '0;
            r_reg   <= '0;
            r_dat   <= '0;
            r_cnt   <= '0;
            r_set   <= '0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_a0    <= w_a0_nx;
            r_we    <= w_we_nx;
            r_do    <= w_do_nx;
            r_reg   <= w_reg_nx;
            r_dat   <= w_dat_nx;
            r_cnt   <= w_cnt_nx;
            r_set   <= w_set_nx;
            r_to    <= w_to_nx;
        end
    end

    assign IN_READY = w_ready;
    assign YM_SEL   = r_sel;
    assign YM_A0    = r_a0;
    assign YM_WE    = r_we;
    assign YM_DO    = r_do;
    assign LEVEL    = r_level;
    assign BUSY     = (r_state != S_IDLE) || (r_level != '0);
    assign TIMEOUT  = r_to;

endmodule

`default_nettype wire

// File: tb/tb_ym_reg_writer.sv
// ============================================================================
//  Module   : tb_ym_reg_writer
//  Purpose  : Self-checking bench for ym_reg_writer with a behavioural chip model
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ym_reg_writer;

    localparam int SETTLE = 1;
    localparam int PMAX   = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CE_CPU = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       IN_CHIP = 1'b0;
    logic [7:0] IN_REG = '0;
    logic [7:0] IN_DATA = '0;
    logic       IN_READY, YM_SEL, YM_A0, YM_WE, BUSY, TIMEOUT;
    logic [7:0] YM_DO;
    logic [7:0] YM_DI;
    logic [4:0] LEVEL;

    ym_reg_writer #(.DEPTH(16), .POLL_EN(1), .SETTLE(SETTLE), .POLL_MAX(PMAX)) dut (
        .CLK(CLK), .RESET(RESET), .CE_CPU(CE_CPU), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_CHIP(IN_CHIP), .IN_REG(IN_REG), .IN_DATA(IN_DATA), .YM_SEL(YM_SEL), .YM_A0(YM_A0),
        .YM_WE(YM_WE), .YM_DO(YM_DO), .YM_DI(YM_DI), .LEVEL(LEVEL), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    int tests = 0, fails = 0;
    int ph = 0, rd_idx = 0;
    logic ce_en = 1'b0, ce_prev = 1'b0;

    // Chip model: latches writes, reports busy for busy_cfg status reads after an FM write.
    int         busy_cfg = 0, busy_left = 0, poll_tot = 0, log_n = 0, presc = 3;
    logic [7:0] m_addr = '0;
    logic       m_sel = 1'b0;
    logic [17:0] log_a [64];

    function automatic logic is_fm(input logic [7:0] r);
        return (r >= 8'h10) && !((r >= 8'h2D) && (r <= 8'h2F));
    endfunction

    assign YM_DI = {busy_left > 0, 7'h00};

    always @(posedge CLK) begin
        if (RESET) begin
            busy_left <= 0;
        end else if (CE_CPU) begin
            if (YM_WE && !YM_A0) begin
                m_addr <= YM_DO;
                m_sel  <= YM_SEL;
            end else if (YM_WE && YM_A0) begin
                if (log_n < 64) log_a[log_n] <= {m_sel, YM_SEL, m_addr, YM_DO};
                log_n     <= log_n + 1;
                busy_left <= is_fm(m_addr) ? busy_cfg : 0;
                if (m_addr == 8'h2D) presc <= 2;
                if (m_addr == 8'h2E) presc <= 1;
                if (m_addr == 8'h2F) presc <= 0;
            end else if (!YM_WE && !YM_A0) begin
                poll_tot <= poll_tot + 1;
                if (busy_left > 0) busy_left <= busy_left - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        ce_prev = CE_CPU;
        #1;
        ph++;
        CE_CPU = ce_en && ((ph % 4) == 0);
    endtask

    task automatic wait_strobe();
        int n = 0;
        do begin tick(); n++; end while (!ce_prev && n < 16);
        chk("strobe_wait", {31'd0, ce_prev}, 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        do begin tick(); n++; end while (BUSY && n < bound);
        chk("idle_wait", {31'd0, BUSY}, 32'd0);
    endtask

    task automatic push(input logic ch, input logic [7:0] r, input logic [7:0] d);
        IN_VALID = 1'b1; IN_CHIP = ch; IN_REG = r; IN_DATA = d;
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic chk_log(input string tag, input logic ch, input logic [7:0] r, input logic [7:0] d);
        chk(tag, {14'd0, log_a[rd_idx]}, {14'd0, ch, ch, r, d});
        rd_idx++;
    endtask

    task automatic run_one(input string tag, input logic ch, input logic [7:0] r,
                           input logic [7:0] d, input int k);
        int p0;
        busy_cfg = SETTLE + k;
        p0 = poll_tot;
        push(ch, r, d);
        wait_idle(400);
        chk({tag, "_count"}, log_n, rd_idx + 1);
        chk_log({tag, "_txn"}, ch, r, d);
        chk({tag, "_polls"}, poll_tot - p0, is_fm(r) ? SETTLE + ((k < PMAX) ? k + 1 : PMAX) : 0);
    endtask

    initial begin
        int p0;
        logic [7:0] rr;
        repeat (4) tick();
        RESET = 1'b0;
        tick();
        chk("rst_sel", {31'd0, YM_SEL}, 0);
        chk("rst_a0", {31'd0, YM_A0}, 1);
        chk("rst_we", {31'd0, YM_WE}, 0);
        chk("rst_do", {24'd0, YM_DO}, 0);
        chk("rst_level", {27'd0, LEVEL}, 0);
        chk("rst_busy", {31'd0, BUSY}, 0);
        chk("rst_timeout", {31'd0, TIMEOUT}, 0);
        chk("rst_ready", {31'd0, IN_READY}, 1);
        ce_en = 1'b1;

        // PSG write: address phase after first strobe, then data, no poll
        p0 = poll_tot;
        push(1'b0, 8'h07, 8'h38);
        wait_strobe();
        chk("t1_addr", {29'd0, YM_SEL, YM_A0, YM_WE}, 32'b001);
        chk("t1_addr_do", {24'd0, YM_DO}, 32'h07);
        wait_strobe();
        chk("t1_data", {30'd0, YM_A0, YM_WE}, 32'b11);
        chk("t1_data_do", {24'd0, YM_DO}, 32'h38);
        wait_strobe();
        chk("t1_end", {29'd0, YM_A0, YM_WE, BUSY}, 32'b100);
        chk("t1_polls", poll_tot - p0, 0);
        chk_log("t1_txn", 1'b0, 8'h07, 8'h38);

        // FM write on chip 1 with three counted busy samples
        run_one("t2", 1'b1, 8'hA0, 8'h55, 3);
        chk("t2_timeout", {31'd0, TIMEOUT}, 0);

        for (int i = 0; i < 8; i++) begin
            rr = 8'($urandom_range(0, 255));
            run_one("rnd", 1'($urandom_range(0, 1)), rr, 8'($urandom), $urandom_range(0, 3));
            chk("rnd_timeout", {31'd0, TIMEOUT}, 0);
        end

        // Busy stuck: poll exhausts, TIMEOUT sticks, next request still runs
        run_one("t3", 1'b0, 8'h28, 8'hF0, 50);
        chk("t3_timeout", {31'd0, TIMEOUT}, 1);
        run_one("t3_next", 1'b1, 8'h08, 8'h0F, 0);
        chk("t3_sticky", {31'd0, TIMEOUT}, 1);

        // Prescaler registers never poll
        run_one("t4a", 1'b0, 8'h2D, 8'h00, 5);
        chk("t4_presc2d", presc, 2);
        run_one("t4b", 1'b0, 8'h2E, 8'h00, 5);
        run_one("t4c", 1'b0, 8'h2F, 8'h00, 5);
        chk("t4_presc", presc, 0);

        // Push and pop on the same edge keeps LEVEL
        ce_en = 1'b0;
        repeat (2) tick();
        push(1'b0, 8'h01, 8'hA1);
        push(1'b0, 8'h02, 8'hA2);
        chk("pp_level2", {27'd0, LEVEL}, 2);
        CE_CPU = 1'b1; IN_VALID = 1'b1; IN_CHIP = 1'b0; IN_REG = 8'h03; IN_DATA = 8'hA3;
        @(posedge CLK); #1;
        CE_CPU = 1'b0; IN_VALID = 1'b0;
        chk("pp_level_same", {27'd0, LEVEL}, 2);
        ce_en = 1'b1;
        wait_idle(400);
        for (int i = 1; i <= 3; i++) chk_log("pp_order", 1'b0, 8'(i), 8'(8'hA0 + i));

        // Fill with strobes held off: 17th request dropped
        ce_en = 1'b0;
        repeat (2) tick();
        IN_VALID = 1'b1;
        for (int i = 0; i < 17; i++) begin
            IN_CHIP = 1'(i); IN_REG = 8'(i); IN_DATA = 8'(8'h40 + i);
            tick();
            chk("fill_level", {27'd0, LEVEL}, (i + 1 > 16) ? 16 : i + 1);
        end
        IN_VALID = 1'b0;
        chk("fill_ready", {31'd0, IN_READY}, 0);
        ce_en = 1'b1;
        wait_idle(1000);
        chk("fill_count", log_n, rd_idx + 16);
        for (int i = 0; i < 16; i++) chk_log("fill_order", 1'(i), 8'(i), 8'(8'h40 + i));

        // Reset during the data phase
        busy_cfg = 2;
        push(1'b1, 8'h40, 8'h12);
        push(1'b0, 8'h05, 8'h01);
        begin
            int n = 0;
            while (!(YM_WE && YM_A0) && n < 100) begin tick(); n++; end
        end
        chk("t6_in_data", {30'd0, YM_WE, YM_A0}, 32'b11);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("t6_a0we", {30'd0, YM_A0, YM_WE}, 32'b10);
        chk("t6_level", {27'd0, LEVEL}, 0);
        chk("t6_busy", {31'd0, BUSY}, 0);
        chk("t6_timeout", {31'd0, TIMEOUT}, 0);
        repeat (20) tick();
        chk("t6_lost", log_n, rd_idx);
        chk("t6_idle", {31'd0, BUSY}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
